// File: rtl/sar_search.sv
// sar_search -- successive-approximation search controller.
//
// Drives the b operand of a combinational magnitude comparator and resolves
// the unknown value on the comparator's a input. Bits are decided MSB-first,
// one comparison per clock. An aeb flag ends the search early.
//
// Ports
//   clk, rst          rising-edge clock; asynchronous active-high reset
//   start             request a search (accepted only while idle)
//   agb, alb, aeb     comparator flags for the current trial (a>b, a<b, a==b)
//   trial  [N-1:0]    registered value presented to the comparator's b input
//   busy              high while a search is in progress
//   done              one-cycle pulse on the cycle the result becomes valid
//   result [N-1:0]    resolved value, held until the next accepted start
//   err               flags were not consistent; held with result
//   steps  [SW-1:0]   comparisons used by the last search; held with result
module sar_search #(
   parameter int N  = 32,
   parameter int SW = $clog2(N+1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          agb,
   input  logic          alb,
   input  logic          aeb,
   output logic [N-1:0]  trial,
   output logic          busy,
   output logic          done,
   output logic [N-1:0]  result,
   output logic          err,
   output logic [SW-1:0] steps
);

   localparam int IW = $clog2(N);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] SEARCH = 1'b1;

   localparam logic [N-1:0] ONE = N'(1);
   localparam logic [N-1:0] MSB = {1'b1, {(N-1){1'b0}}};

   logic [0:0]    state_q, state_d;
   logic [IW-1:0] i_q, i_d;
   logic [N-1:0]  acc_q, acc_d;
   logic [N-1:0]  trial_q, trial_d;
   logic [N-1:0]  result_q, result_d;
   logic          err_q, err_d;
   logic [SW-1:0] steps_q, steps_d;
   logic          done_q, done_d;
   logic          flags_ok;

   // Exactly one flag must be high for a consistent comparator answer.
   always_comb begin
      case ({agb, alb, aeb})
         3'b100, 3'b010, 3'b001: flags_ok = 1'b1;
         default:                flags_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      i_d      = i_q;
      acc_d    = acc_q;
      trial_d  = trial_q;
      result_d = result_q;
      err_d    = err_q;
      steps_d  = steps_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = SEARCH;
               i_d      = IW'(N-1);
               acc_d    = '0;
               trial_d  = MSB;
               steps_d  = '0;
               err_d    = 1'b0;
               result_d = '0;
            end
         end

         SEARCH: begin
            steps_d = steps_q + SW'(1);
            if (!flags_ok) begin
               err_d    = 1'b1;
               result_d = acc_q;
               done_d   = 1'b1;
               state_d  = IDLE;
            end else if (aeb) begin
               result_d = trial_q;
               done_d   = 1'b1;
               state_d  = IDLE;
            end else if (agb && (i_q == '0)) begin
               // a above a trial whose LSB is already set cannot happen if the
               // comparator is consistent; report what was being tried.
               err_d    = 1'b1;
               result_d = trial_q;
               done_d   = 1'b1;
               state_d  = IDLE;
            end else begin
               if (agb) acc_d = trial_q;
               if (i_q == '0) begin
                  result_d = acc_d;
                  done_d   = 1'b1;
                  state_d  = IDLE;
               end else begin
                  // Next trial builds on the just-updated accumulator.
                  i_d     = i_q - IW'(1);
                  trial_d = acc_d | (ONE << (i_q - IW'(1)));
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         i_q      <= '0;
         acc_q    <= '0;
         trial_q  <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         steps_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         i_q      <= i_d;
         acc_q    <= acc_d;
         trial_q  <= trial_d;
         result_q <= result_d;
         err_q    <= err_d;
         steps_q  <= steps_d;
         done_q   <= done_d;
      end
   end

   assign trial  = trial_q;
   assign busy   = (state_q == SEARCH);
   assign done   = done_q;
   assign result = result_q;
   assign err    = err_q;
   assign steps  = steps_q;

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: an N=8 instance for the directed, fault,
// handshake and reset cases, and an N=32 instance swept with random operands.
module tb_sar_search;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errs   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- N=8 instance with a fault-injecting comparator model
   logic       start8 = 1'b0;
   logic [7:0] a8     = '0;
   logic       ovr8   = 1'b0;
   logic [2:0] ovf8   = '0;
   logic       agb8, alb8, aeb8;
   logic [7:0] trial8, result8;
   logic       busy8, done8, err8;
   logic [3:0] steps8;

   assign {agb8, alb8, aeb8} = ovr8 ? ovf8 : {a8 > trial8, a8 < trial8, a8 == trial8};

   sar_search #(.N(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8),
      .agb(agb8), .alb(alb8), .aeb(aeb8),
      .trial(trial8), .busy(busy8), .done(done8),
      .result(result8), .err(err8), .steps(steps8)
   );

   // ---------------- N=32 instance, consistent comparator
   logic        start32 = 1'b0;
   logic [31:0] a32     = '0;
   logic        agb32, alb32, aeb32;
   logic [31:0] trial32, result32;
   logic        busy32, done32, err32;
   logic [5:0]  steps32;

   assign agb32 = a32 > trial32;
   assign alb32 = a32 < trial32;
   assign aeb32 = a32 == trial32;

   sar_search #(.N(32)) dut32 (
      .clk(clk), .rst(rst), .start(start32),
      .agb(agb32), .alb(alb32), .aeb(aeb32),
      .trial(trial32), .busy(busy32), .done(done32),
      .result(result32), .err(err32), .steps(steps32)
   );

   logic [7:0] tr8 [0:15];

   // Called at a negedge just after the accepting edge. Records each trial,
   // optionally overrides the flags on comparison number fault_at, and
   // returns at the negedge where done is visible (k = comparisons seen).
   task automatic wait_done8(input int fault_at, input logic [2:0] ff, output int k);
      k = 0;
      for (int c = 1; c <= 20; c++) begin
         ovr8 = (c == fault_at);
         ovf8 = ff;
         tr8[(c-1) % 16] = trial8;
         @(negedge clk);
         k = c;
         if (done8) break;
      end
      ovr8 = 1'b0;
      if (!done8) chk("timeout8", 64'd0, 64'd1);
   endtask

   task automatic run8(input logic [7:0] a, input int fault_at, input logic [2:0] ff, output int k);
      a8     = a;
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      wait_done8(fault_at, ff, k);
   endtask

   // Expected comparisons for a consistent comparator: aeb hits when the
   // trial reaches a's lowest set bit; a==0 runs the full width.
   function automatic int exp_steps(input logic [31:0] a, input int n);
      if (a == '0) return n;
      for (int b = 0; b < n; b++)
         if (a[b]) return n - b;
      return n;
   endfunction

   logic [7:0] seq5a [0:6];
   logic [7:0] w;
   int         k;

   initial begin
      seq5a = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A};

      // ---- reset state
      repeat (2) @(negedge clk);
      chk("rst_trial",  64'(trial8),  64'd0);
      chk("rst_busy",   64'(busy8),   64'd0);
      chk("rst_done",   64'(done8),   64'd0);
      chk("rst_result", 64'(result8), 64'd0);
      chk("rst_err",    64'(err8),    64'd0);
      chk("rst_steps",  64'(steps8),  64'd0);
      rst = 1'b0;
      @(negedge clk);

      // ---- a=0x5A: trial sequence and early aeb exit
      a8 = 8'h5A; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      chk("busy_after_start", 64'(busy8), 64'd1);
      chk("first_trial", 64'(trial8), 64'h80);
      wait_done8(0, 3'b000, k);
      for (int j = 0; j < 7; j++) chk("seq5a", 64'(tr8[j]), 64'(seq5a[j]));
      chk("5a_result", 64'(result8), 64'h5A);
      chk("5a_steps",  64'(steps8),  64'd7);
      chk("5a_err",    64'(err8),    64'd0);
      chk("5a_busy",   64'(busy8),   64'd0);
      chk("5a_lat",    64'(k),       64'd7);
      @(negedge clk);
      chk("done_pulse", 64'(done8), 64'd0);

      // ---- boundaries
      run8(8'h00, 0, 3'b000, k);
      for (int j = 0; j < 8; j++) begin
         w = 8'h80 >> j;
         chk("walk00", 64'(tr8[j]), 64'(w));
      end
      chk("00_result", 64'(result8), 64'h00);
      chk("00_steps",  64'(steps8),  64'd8);
      chk("00_err",    64'(err8),    64'd0);
      run8(8'hFF, 0, 3'b000, k);
      chk("ff_result", 64'(result8), 64'hFF);
      chk("ff_steps",  64'(steps8),  64'd8);
      run8(8'h80, 0, 3'b000, k);
      chk("80_result", 64'(result8), 64'h80);
      chk("80_steps",  64'(steps8),  64'd1);

      // ---- fault injection
      run8(8'h5A, 3, 3'b110, k);
      chk("f3_err",    64'(err8),    64'd1);
      chk("f3_steps",  64'(steps8),  64'd3);
      chk("f3_result", 64'(result8), 64'h40);
      run8(8'h5A, 1, 3'b000, k);
      chk("f1_err",    64'(err8),    64'd1);
      chk("f1_steps",  64'(steps8),  64'd1);
      chk("f1_result", 64'(result8), 64'h00);
      run8(8'h00, 8, 3'b100, k);
      chk("lsb_err",    64'(err8),    64'd1);
      chk("lsb_result", 64'(result8), 64'h01);
      chk("lsb_steps",  64'(steps8),  64'd8);

      // ---- start held high: ignored mid-search, restarts the cycle after done
      a8 = 8'h5A; start8 = 1'b1;
      @(negedge clk);
      wait_done8(0, 3'b000, k);
      chk("hold_result", 64'(result8), 64'h5A);
      chk("hold_steps",  64'(steps8),  64'd7);
      @(negedge clk);
      start8 = 1'b0;
      chk("restart_busy",   64'(busy8),   64'd1);
      chk("restart_trial",  64'(trial8),  64'h80);
      chk("restart_result", 64'(result8), 64'h00);
      wait_done8(0, 3'b000, k);
      chk("hold2_result", 64'(result8), 64'h5A);
      chk("hold2_lat",    64'(k),       64'd7);

      // ---- results hold while idle
      run8(8'h33, 0, 3'b000, k);
      repeat (5) @(negedge clk);
      chk("hold_idle_result", 64'(result8), 64'h33);
      chk("hold_idle_steps",  64'(steps8),  64'd8);
      chk("hold_idle_trial",  64'(trial8),  64'h33);
      chk("hold_idle_busy",   64'(busy8),   64'd0);

      // ---- asynchronous reset in the 4th search cycle
      a8 = 8'h5A; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_rst_busy", 64'(busy8), 64'd1);
      rst = 1'b1;
      #1;
      chk("arst_trial",  64'(trial8),  64'd0);
      chk("arst_busy",   64'(busy8),   64'd0);
      chk("arst_result", 64'(result8), 64'd0);
      chk("arst_steps",  64'(steps8),  64'd0);
      chk("arst_err",    64'(err8),    64'd0);
      @(negedge clk);
      chk("arst_done", 64'(done8), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("arst_nodone", 64'(done8), 64'd0);
      run8(8'h33, 0, 3'b000, k);
      chk("post_rst_result", 64'(result8), 64'h33);

      // ---- N=32 sweep
      for (int n = 0; n < 1000; n++) begin
         case (n)
            0:       a32 = 32'h0000_0000;
            1:       a32 = 32'hFFFF_FFFF;
            2:       a32 = 32'h0000_0001;
            3:       a32 = 32'h8000_0000;
            default: a32 = $urandom;
         endcase
         start32 = 1'b1;
         @(negedge clk);
         start32 = 1'b0;
         k = 0;
         for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            k = c;
            if (done32) break;
         end
         if (!done32) chk("timeout32", 64'd0, 64'd1);
         chk("r32_result", 64'(result32), 64'(a32));
         chk("r32_err",    64'(err32),    64'd0);
         chk("r32_steps",  64'(steps32),  64'(exp_steps(a32, 32)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
      $finish;
   end

endmodule
